// File: rtl/aes_enc128_core_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_enc128_core_if                                              |
// | Purpose  : Plaintext-in / ciphertext-out handshake bundle for the          |
// |            iterative AES-128 encryption core.                              |
// | Signals  : pt[127:0]  plaintext, pt[127:120] is FIPS-197 byte 0            |
// |            pt_valid   plaintext offered            (master -> slave)       |
// |            pt_ready   core can accept plaintext    (slave  -> master)      |
// |            ct[127:0]  ciphertext, same byte order  (slave  -> master)      |
// |            ct_valid   ciphertext valid             (slave  -> master)      |
// |            ct_ready   consumer takes ciphertext    (master -> slave)       |
// | Modports : slave  - the encryption core                                   |
// |            master - the block feeding plaintext and draining ciphertext    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface aes_enc128_core_if;
  logic [127:0] pt;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] ct;
  logic         ct_valid;
  logic         ct_ready;

  modport slave (
    input  pt,
    input  pt_valid,
    output pt_ready,
    output ct,
    output ct_valid,
    input  ct_ready
  );

  modport master (
    output pt,
    output pt_valid,
    input  pt_ready,
    input  ct,
    input  ct_valid,
    output ct_ready
  );
endinterface
`default_nettype wire

// File: rtl/aes_enc128_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_enc128_core                                                 |
// | Purpose  : Iterative AES-128 encryption, one round per clock. Consumes     |
// |            the eleven round keys from key expansion and encrypts one       |
// |            128-bit block at a time (no overlap between blocks).            |
// | Ports    : clk       rising-edge clock                                     |
// |            rst_n     asynchronous active-low reset                         |
// |            rk_flat   round keys, key i at [128*i+127 : 128*i], i=0 cipher  |
// |            rk_rdy    round keys valid; gates plaintext acceptance only     |
// |            bus       plaintext/ciphertext handshakes (slave modport)       |
// |            busy      a block is in flight                                  |
// | Latency  : acceptance at edge E, ct_valid high after edge E+10             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module aes_enc128_core #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [128*(NR+1)-1:0] rk_flat,
  input  logic                  rk_rdy,
  aes_enc128_core_if.slave      bus,
  output logic                  busy
);

  // Forward S-box, row 0 in the most significant 128 bits; entry a sits
  // at bit offset 8*(255-a), i.e. {~a, 3'b000}.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] sbox(input logic [7:0] a);
    return C_SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; a[31:24] is the row-0 byte.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
    b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  fsm_t         r_fsm;
  fsm_t         w_fsm_nxt;
  logic [3:0]   r_rnd;
  logic [127:0] r_state;
  logic [127:0] r_ct;
  logic         r_ct_valid;

  logic         w_pt_ready;
  logic         w_accept;
  logic         w_last;
  logic [127:0] w_rk_arr [16];
  logic [127:0] w_rk;
  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;
  logic [127:0] w_round;

  // Round keys unpacked into a 16-deep table so the 4-bit round counter
  // indexes it directly; slots beyond NR are never selected and read zero.
  generate
    for (genvar g = 0; g < 16; g++) begin : g_rk
      if (g <= NR) begin : g_key
        assign w_rk_arr[g] = rk_flat[128*g +: 128];
      end else begin : g_pad
        assign w_rk_arr[g] = '0;
      end
    end
  endgenerate

  assign w_rk = w_rk_arr[r_rnd];

  // SubBytes: one S-box per state byte; byte k is at [127-8k -: 8].
  generate
    for (genvar k = 0; k < 16; k++) begin : g_sbox
      assign w_sb[127-8*k -: 8] = sbox(r_state[127-8*k -: 8]);
    end
  endgenerate

  // ShiftRows: byte (row r, col c) = index r+4c takes from column (c+r)%4.
  generate
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      for (genvar c = 0; c < 4; c++) begin : g_sr_col
        localparam int SRC = r + 4*((c + r) % 4);
        assign w_sr[127-8*(r+4*c) -: 8] = w_sb[127-8*SRC -: 8];
      end
    end
  endgenerate

  generate
    for (genvar c = 0; c < 4; c++) begin : g_mc
      assign w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end
  endgenerate

  assign w_last  = (r_rnd == 4'(NR));
  // The final round skips MixColumns.
  assign w_round = (w_last ? w_sr : w_mc) ^ w_rk;

  // Qualified with rst_n so pt_ready reads 0 for the whole reset window,
  // even when rk_rdy is already high.
  assign w_pt_ready = rst_n && (r_fsm == S_IDLE) && rk_rdy;
  assign w_accept   = bus.pt_valid && w_pt_ready;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (w_accept)     w_fsm_nxt = S_ROUND;
      S_ROUND: if (w_last)       w_fsm_nxt = S_DONE;
      S_DONE:  if (bus.ct_ready) w_fsm_nxt = S_IDLE;
      default:                   w_fsm_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rnd      <= 4'd0;
      r_state    <= '0;
      r_ct       <= '0;
      r_ct_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= bus.pt ^ w_rk_arr[0];
            r_rnd   <= 4'd1;
          end
        end
        S_ROUND: begin
          r_state <= w_round;
          if (w_last) begin
            r_ct       <= w_round;
            r_ct_valid <= 1'b1;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        S_DONE: begin
          // ct keeps its value after the handshake; only valid drops.
          if (bus.ct_ready) begin
            r_ct_valid <= 1'b0;
          end
        end
        default: begin
          r_ct_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pt_ready = w_pt_ready;
  assign bus.ct       = r_ct;
  assign bus.ct_valid = r_ct_valid;
  assign busy         = (r_fsm != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_enc128_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_enc128_core                                              |
// | Purpose  : Directed self-checking bench for aes_enc128_core: FIPS-197      |
// |            vectors, key gating, backpressure, back-to-back blocks and      |
// |            asynchronous reset in mid-block.                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_aes_enc128_core;
  localparam int NR = 10;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                  clk;
  logic                  rst_n;
  logic [128*(NR+1)-1:0] rk_flat;
  logic                  rk_rdy;
  logic                  busy;

  aes_enc128_core_if bus();

  aes_enc128_core #(.NR(NR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rk_flat (rk_flat),
    .rk_rdy  (rk_rdy),
    .bus     (bus),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // --------------------------------------------------------------------------
  // Reference model: S-box built from the GF(2^8) inverse and affine map
  // --------------------------------------------------------------------------
  logic [7:0] sb_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, xb, yb;
    for (int x = 0; x < 256; x++) begin
      xb  = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        yb = 8'(y);
        if (x != 0 && gmul(xb, yb) == 8'h01) inv = yb;
      end
      sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^
                  rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [128*(NR+1)-1:0] ref_kexp(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [128*(NR+1)-1:0] rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
        t = t ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j <= NR; j++)
      rk[128*j +: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return rk;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] p,
                                           input logic [128*(NR+1)-1:0] rk);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = p ^ rk[127:0];
    for (int r = 1; r <= NR; r++) begin
      for (int k = 0; k < 16; k++) t[127-8*k -: 8] = sb_tab[s[127-8*k -: 8]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          s[127-8*(row+4*c) -: 8] = t[127-8*(row+4*((c+row)%4)) -: 8];
      if (r != NR) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          s[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      s = s ^ rk[128*r +: 128];
    end
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers p until accepted; returns just after the acceptance edge.
  task automatic accept_block(input logic [127:0] p, output bit ok);
    ok = 1'b0;
    bus.pt       = p;
    bus.pt_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.pt_ready === 1'b1) begin
        tick();
        bus.pt_valid = 1'b0;
        ok = 1'b1;
        return;
      end
      tick();
    end
    bus.pt_valid = 1'b0;
  endtask

  // Counts edges until ct_valid is seen (bounded by limit).
  task automatic wait_ct(input int limit, output int lat);
    lat = 0;
    while (bus.ct_valid !== 1'b1 && lat < limit) begin
      tick();
      lat++;
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; rk_rdy = 1'b1; rk_flat = ref_kexp(KEY_B);
    bus.pt = '0; bus.pt_valid = 1'b0; bus.ct_ready = 1'b0;
    repeat (3) tick();
    checks++; if (bus.pt_ready !== 1'b0) begin errors++; $display("FAIL reset_pt_ready: got %b want 0", bus.pt_ready); end
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("FAIL reset_ct_valid: got %b want 0", bus.ct_valid); end
    checks++; if (bus.ct !== 128'h0) begin errors++; $display("FAIL reset_ct: got %h want 0", bus.ct); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    checks++; if (bus.pt_ready !== 1'b1) begin errors++; $display("FAIL post_reset_pt_ready: got %b want 1", bus.pt_ready); end
  endtask

  task automatic test_fips_b();
    bit ok; int lat;
    rk_flat = ref_kexp(KEY_B); rk_rdy = 1'b1; bus.ct_ready = 1'b1;
    accept_block(PT_B, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b_accept: got timeout want acceptance"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b_busy: got %b want 1", busy); end
    checks++; if (bus.pt_ready !== 1'b0) begin errors++; $display("FAIL b_pt_ready_round: got %b want 0", bus.pt_ready); end
    wait_ct(30, lat);
    checks++; if (lat !== 10 || bus.ct_valid !== 1'b1) begin errors++; $display("FAIL b_latency: got %0d want 10", lat); end
    checks++; if (bus.ct !== CT_B) begin errors++; $display("FAIL b_ct: got %h want %h", bus.ct, CT_B); end
    tick();
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("FAIL b_ct_valid_pulse: got %b want 0", bus.ct_valid); end
    checks++; if (busy !== 1'b0 || bus.pt_ready !== 1'b1) begin errors++; $display("FAIL b_idle: got busy=%b pt_ready=%b want 0/1", busy, bus.pt_ready); end
    checks++; if (bus.ct !== CT_B) begin errors++; $display("FAIL b_ct_hold: got %h want %h", bus.ct, CT_B); end
  endtask

  task automatic test_fips_c();
    bit ok; int lat;
    rk_flat = ref_kexp(KEY_C); rk_rdy = 1'b1; bus.ct_ready = 1'b1;
    accept_block(PT_C, ok);
    checks++; if (!ok) begin errors++; $display("FAIL c_accept: got timeout want acceptance"); end
    wait_ct(30, lat);
    checks++; if (lat !== 10 || bus.ct_valid !== 1'b1) begin errors++; $display("FAIL c_latency: got %0d want 10", lat); end
    checks++; if (bus.ct !== CT_C) begin errors++; $display("FAIL c_ct: got %h want %h", bus.ct, CT_C); end
    tick();
  endtask

  task automatic test_key_gating();
    int lat;
    rk_flat = ref_kexp(KEY_C); rk_rdy = 1'b0; bus.ct_ready = 1'b1;
    bus.pt = PT_C; bus.pt_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.pt_ready !== 1'b0 || busy !== 1'b0 || bus.ct_valid !== 1'b0) begin
        errors++;
        $display("FAIL gate_cycle%0d: got pt_ready=%b busy=%b ct_valid=%b want 0/0/0",
                 i, bus.pt_ready, busy, bus.ct_valid);
      end
    end
    rk_rdy = 1'b1;
    #1;
    checks++; if (bus.pt_ready !== 1'b1) begin errors++; $display("FAIL gate_release_ready: got %b want 1", bus.pt_ready); end
    tick();
    bus.pt_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_accept_busy: got %b want 1", busy); end
    wait_ct(30, lat);
    checks++; if (bus.ct !== CT_C || lat !== 10) begin errors++; $display("FAIL gate_ct: got %h lat %0d want %h lat 10", bus.ct, lat, CT_C); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    rk_flat = ref_kexp(KEY_B); rk_rdy = 1'b1; bus.ct_ready = 1'b0;
    accept_block(PT_B, ok);
    wait_ct(30, lat);
    checks++; if (!ok || bus.ct_valid !== 1'b1) begin errors++; $display("FAIL bp_ct_valid: got %b want 1", bus.ct_valid); end
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (bus.ct_valid !== 1'b1 || bus.ct !== CT_B) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid=%b ct=%h want 1 %h", i, bus.ct_valid, bus.ct, CT_B);
      end
    end
    bus.ct_ready = 1'b1;
    tick();
    bus.ct_ready = 1'b0;
    checks++; if (bus.ct_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.ct_valid); end
    checks++; if (bus.pt_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.pt_ready); end
    checks++; if (bus.ct !== CT_B) begin errors++; $display("FAIL bp_ct_keep: got %h want %h", bus.ct, CT_B); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] key;
    logic [127:0] pts [4];
    logic [127:0] exp_ct [4];
    int acc_cyc [4];
    int n_acc, n_ct, cyc;
    bit will_acc;
    key = {$urandom, $urandom, $urandom, $urandom};
    rk_flat = ref_kexp(key);
    for (int i = 0; i < 4; i++) begin
      pts[i]    = {$urandom, $urandom, $urandom, $urandom};
      exp_ct[i] = ref_enc(pts[i], rk_flat);
      acc_cyc[i] = 0;
    end
    rk_rdy = 1'b1; bus.ct_ready = 1'b1;
    bus.pt = pts[0]; bus.pt_valid = 1'b1;
    n_acc = 0; n_ct = 0; cyc = 0;
    while (cyc < 120 && n_ct < 4) begin
      if (bus.ct_valid === 1'b1) begin
        checks++;
        if (bus.ct !== exp_ct[n_ct]) begin
          errors++;
          $display("FAIL b2b_ct%0d: got %h want %h", n_ct, bus.ct, exp_ct[n_ct]);
        end
        n_ct++;
      end
      will_acc = (bus.pt_valid === 1'b1) && (bus.pt_ready === 1'b1);
      tick();
      cyc++;
      if (will_acc && n_acc < 4) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc < 4) bus.pt = pts[n_acc];
        else bus.pt_valid = 1'b0;
      end
    end
    bus.pt_valid = 1'b0;
    checks++; if (n_acc != 4 || n_ct != 4) begin errors++; $display("FAIL b2b_count: got acc=%0d ct=%0d want 4/4", n_acc, n_ct); end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 12) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d want 12", i, acc_cyc[i] - acc_cyc[i-1]);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; bit seen;
    rk_flat = ref_kexp(KEY_B); rk_rdy = 1'b1; bus.ct_ready = 1'b1;
    // Leave a known non-zero ct behind so the reset clear is visible.
    accept_block(PT_B, ok);
    wait_ct(30, lat);
    tick();
    accept_block(PT_B, ok);
    repeat (4) tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ct_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got valid=%b busy=%b want 0/0", bus.ct_valid, busy); end
    checks++; if (bus.ct !== 128'h0) begin errors++; $display("FAIL mid_rst_ct: got %h want 0", bus.ct); end
    checks++; if (bus.pt_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_pt_ready: got %b want 0", bus.pt_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.ct_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL mid_rst_no_ct: got activity after reset want none"); end
    accept_block(PT_B, ok);
    wait_ct(30, lat);
    checks++; if (!ok || lat !== 10 || bus.ct !== CT_B) begin errors++; $display("FAIL mid_rst_rerun: got %h lat %0d want %h lat 10", bus.ct, lat, CT_B); end
    tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c();
    test_key_gating();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
